// File: rtl/exa_crosb_out_arbiter.sv
// exa_crosb_out_arbiter
// Output-port packet arbiter for the crossbar. It selects one requesting input
// using a round-robin scan in which high-priority requesters go first. It then
// holds that grant until the packet ends, either on LAST or on a forced release
// after max_beats transfers. SEL_o, GRANT_o, BUSY_o and ERR_o are all registered.

module exa_crosb_out_arbiter #(
  parameter int input_num = 16,
  parameter int sel_width = (input_num > 1) ? $clog2(input_num) : 1,
  parameter int max_beats = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [input_num-1:0] REQ_i,
  input  logic [input_num-1:0] PRIO_i,
  input  logic                 VALID_i,
  input  logic                 LAST_i,
  input  logic                 READY_i,
  output logic [sel_width-1:0] SEL_o,
  output logic [input_num-1:0] GRANT_o,
  output logic                 BUSY_o,
  output logic                 ERR_o
);

  localparam int cnt_width = $clog2(max_beats);
  localparam logic [cnt_width-1:0] cnt_last = cnt_width'(max_beats - 1);
  localparam logic [sel_width-1:0] ptr_init = sel_width'(input_num - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Reset synchroniser: assertion is immediate, deassertion is aligned to clk.
  logic [1:0] rst_sync_r;
  logic       rst_int_n_s;

  state_t                 state_r, state_s;
  logic [sel_width-1:0]   sel_r, sel_s;
  logic [input_num-1:0]   grant_r, grant_s;
  logic                   busy_r, busy_s;
  logic                   err_r, err_s;
  logic [sel_width-1:0]   ptr_r, ptr_s;
  logic [cnt_width-1:0]   cnt_r, cnt_s;

  logic [input_num-1:0]   cand_s;
  logic                   win_found_s;
  logic [sel_width-1:0]   win_idx_s;
  logic [input_num-1:0]   win_hot_s;
  logic                   xfer_s;
  logic                   last_rel_s;
  logic                   force_rel_s;
  logic                   release_s;

  // Two-flop reset synchroniser; cleared asynchronously by resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  // Candidate set and round-robin winner search starting just after the pointer.
  always_comb begin
    cand_s      = ((REQ_i & PRIO_i) != '0) ? (REQ_i & PRIO_i) : REQ_i;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 1; i <= input_num; i++) begin
      if (!win_found_s && cand_s[(int'(ptr_r) + i) % input_num]) begin
        win_found_s = 1'b1;
        win_idx_s   = sel_width'((int'(ptr_r) + i) % input_num);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot decode of the winner index.
  always_comb begin
    win_hot_s = '0;
    for (int i = 0; i < input_num; i++) begin
      win_hot_s[i] = (win_idx_s == sel_width'(i));
    end
  end

  // Beat transfer and release qualification while a packet owns the output.
  always_comb begin
    xfer_s      = VALID_i & READY_i;
    last_rel_s  = (state_r == LOCKED) & xfer_s & LAST_i;
    force_rel_s = (state_r == LOCKED) & xfer_s & ~LAST_i & (cnt_r == cnt_last);
    release_s   = last_rel_s | force_rel_s;
  end

  // FSM state register together with the registered outputs and datapath.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r <= IDLE;
      sel_r   <= '0;
      grant_r <= '0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      ptr_r   <= ptr_init;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      sel_r   <= sel_s;
      grant_r <= grant_s;
      busy_r  <= busy_s;
      err_r   <= err_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: lock on any request, unlock on release.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_s = LOCKED;
        end else begin
          state_s = IDLE;
        end
      end
      LOCKED: begin
        if (release_s) begin
          state_s = IDLE;
        end else begin
          state_s = LOCKED;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output/datapath next values; SEL holds across release so the mux never glitches.
  always_comb begin
    sel_s   = sel_r;
    grant_s = grant_r;
    busy_s  = busy_r;
    err_s   = 1'b0;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          sel_s   = win_idx_s;
          grant_s = win_hot_s;
          busy_s  = 1'b1;
          cnt_s   = '0;
        end else begin
          grant_s = '0;
          busy_s  = 1'b0;
        end
      end
      LOCKED: begin
        if (release_s) begin
          grant_s = '0;
          busy_s  = 1'b0;
          ptr_s   = sel_r;
          cnt_s   = '0;
          err_s   = force_rel_s;
        end else if (xfer_s) begin
          cnt_s = cnt_r + cnt_width'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        grant_s = '0;
        busy_s  = 1'b0;
        cnt_s   = '0;
      end
    endcase
  end

  assign SEL_o   = sel_r;
  assign GRANT_o = grant_r;
  assign BUSY_o  = busy_r;
  assign ERR_o   = err_r;

endmodule

// File: tb/tb_exa_crosb_out_arbiter.sv
// Directed bench for exa_crosb_out_arbiter (16 inputs, max_beats=4).
// The bench pushes the expected winner of each arbitration into a queue.
// It pops and checks that entry when the grant appears.

module tb_exa_crosb_out_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] req = 16'h0;
  logic [15:0] prio = 16'h0;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic        ready = 1'b0;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  exa_crosb_out_arbiter #(
    .input_num(16),
    .sel_width(4),
    .max_beats(4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .REQ_i   (req),
    .PRIO_i  (prio),
    .VALID_i (valid),
    .LAST_i  (last),
    .READY_i (ready),
    .SEL_o   (sel),
    .GRANT_o (grant),
    .BUSY_o  (busy),
    .ERR_o   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    valid  = 1'b0;
    last   = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();
    tick();
  endtask

  // Wait (bounded) for a grant, then compare it against the scoreboard head.
  task automatic wait_grant(input string tag, output int waited);
    int w;
    waited = 0;
    while (grant === 16'h0 && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_seen"}, 32'(grant !== 16'h0), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=grant expected=queued entry", tag);
    end else begin
      w = exp_q.pop_front();
      chk({tag, "_grant"}, 32'(grant), 32'(16'h1 << w));
      chk({tag, "_sel"}, 32'(sel), 32'(w));
    end
  endtask

  task automatic do_packet(input int beats, input bit with_last,
                           output int busy_n, output int err_n);
    busy_n = 0;
    err_n  = 0;
    for (int b = 1; b <= beats; b++) begin
      valid = 1'b1;
      ready = 1'b1;
      last  = with_last && (b == beats);
      if (busy === 1'b1) busy_n++;
      tick();
      if (err === 1'b1) err_n++;
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  initial begin
    int waited, bc, ec;

    // Reset state
    tick();
    tick();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    resetn = 1'b1;
    tick();
    tick();
    tick();

    // 1: single requester, 3-beat packet, one-cycle arbitration latency
    req = 16'h0001;
    chk("t1_pre_grant", 32'(grant), 32'd0);
    exp_q.push_back(0);
    tick();
    wait_grant("t1", waited);
    chk("t1_latency", 32'(waited), 32'd0);
    req = 16'h0000;
    do_packet(3, 1'b1, bc, ec);
    chk("t1_busy_cycles", 32'(bc), 32'd3);
    chk("t1_rel_busy", 32'(busy), 32'd0);
    chk("t1_rel_grant", 32'(grant), 32'd0);
    chk("t1_sel_hold", 32'(sel), 32'd0);
    chk("t1_err", 32'(ec), 32'd0);

    // 2: inputs 0 and 2, no priority, single-beat packets alternate
    apply_reset();
    req = 16'h0005;
    exp_q.push_back(0);
    exp_q.push_back(2);
    exp_q.push_back(0);
    exp_q.push_back(2);
    for (int k = 0; k < 4; k++) begin
      wait_grant("t2", waited);
      do_packet(1, 1'b1, bc, ec);
      chk("t2_bubble", 32'(grant), 32'd0);
    end

    // 3: high priority on input 1 always beats input 0
    req  = 16'h0003;
    prio = 16'h0002;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(1);
      wait_grant("t3", waited);
      do_packet(1, 1'b1, bc, ec);
    end
    req  = 16'h0000;
    prio = 16'h0000;
    tick();

    // 4: locked on input 4, stall with READY low, no preemption by priority
    req = 16'h0010;
    exp_q.push_back(4);
    wait_grant("t4", waited);
    req   = 16'h0011;
    prio  = 16'h0001;
    valid = 1'b1;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_stall_grant", 32'(grant), 32'h10);
      chk("t4_stall_busy", 32'(busy), 32'd1);
    end
    ready = 1'b1;
    tick();
    chk("t4_b2_busy", 32'(busy), 32'd1);
    chk("t4_b2_err", 32'(err), 32'd0);
    tick();
    chk("t4_b3_busy", 32'(busy), 32'd1);
    chk("t4_b3_err", 32'(err), 32'd0);
    last = 1'b1;
    tick();
    valid = 1'b0;
    last  = 1'b0;
    chk("t4_rel_busy", 32'(busy), 32'd0);
    chk("t4_rel_grant", 32'(grant), 32'd0);
    chk("t4_rel_err", 32'(err), 32'd0);
    exp_q.push_back(0);
    wait_grant("t4b", waited);
    do_packet(1, 1'b1, bc, ec);
    req  = 16'h0000;
    prio = 16'h0000;
    tick();

    // 5: packet without LAST is cut after max_beats, ERR pulses, rr moves on
    req = 16'h00A0;
    exp_q.push_back(5);
    wait_grant("t5", waited);
    do_packet(4, 1'b0, bc, ec);
    chk("t5_busy_cycles", 32'(bc), 32'd4);
    chk("t5_err_count", 32'(ec), 32'd1);
    chk("t5_err_now", 32'(err), 32'd1);
    chk("t5_rel_busy", 32'(busy), 32'd0);
    chk("t5_rel_grant", 32'(grant), 32'd0);
    exp_q.push_back(7);
    tick();
    chk("t5_err_pulse_end", 32'(err), 32'd0);
    wait_grant("t5b", waited);
    do_packet(2, 1'b1, bc, ec);
    chk("t5b_err", 32'(ec), 32'd0);
    req = 16'h0000;
    tick();

    // 6: reset during beat 2 abandons the packet; afterwards input 0 wins first
    req = 16'h8001;
    exp_q.push_back(15);
    wait_grant("t6", waited);
    valid = 1'b1;
    ready = 1'b1;
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_sel", 32'(sel), 32'd0);
    valid = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    exp_q.push_back(0);
    wait_grant("t6b", waited);
    do_packet(1, 1'b1, bc, ec);
    req = 16'h0000;
    tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
